// File: rtl/aes_block_loader_if.sv
// Word-stream input and result output of the AES block loader.
// The master side feeds 32-bit words and consumes 128-bit results.
// The slave side is the loader itself.
interface aes_block_loader_if;
  // Input word stream
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic         s_sel;

  // Result stream
  logic         m_valid;
  logic         m_ready;
  logic [127:0] m_data;

  modport master (
    output s_valid, s_data, s_sel, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, s_sel, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/aes_block_loader.sv
// Word-serial front end for a fixed-latency AES core.
// Packs 32-bit words into the 128-bit key and plaintext buses. Holds both buses
// steady while the core works, then captures the ciphertext and offers it on a
// valid/ready result port. Only one block is in flight at a time, and the key
// persists across blocks until it is reloaded.
module aes_block_loader #(
  // Core latency in cycles; legal range is 1..255.
  parameter int unsigned LATENCY = 22
) (
  input  logic              clk,
  input  logic              rst,
  aes_block_loader_if.slave bus,
  output logic [127:0]      key,
  output logic [127:0]      plain_text,
  input  logic [127:0]      cypher_text,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Value of the latency counter on the edge that samples the core output.
  localparam logic [7:0] LAST_CNT = 8'(LATENCY - 1);

  state_t            state;
  // Element 3 holds bits [127:96], so word n lands at index ~n.
  logic [3:0][31:0]  key_w;
  logic [3:0][31:0]  pt_w;
  logic [1:0]        kcnt;
  logic [1:0]        pcnt;
  logic              key_loaded;
  logic              pt_full;
  logic [7:0]        lat_cnt;
  logic              m_valid_q;
  logic [127:0]      m_data_q;
  logic              dispatch;

  // A full plaintext block and a complete key, with no half-finished reload.
  // Uses registered values only, so it is evaluated one cycle after the
  // last word has landed.
  assign dispatch = pt_full && key_loaded && (kcnt == 2'd0);

  // Control, packing and result capture as one registered FSM.
  // NOTE: every register here uses non-blocking assignment, so each branch
  // reads pre-edge values. The dispatch test and the word writes in the same
  // cycle therefore cannot see each other's updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the wide key/plaintext/result registers are reset along with
      // the control state. An abandoned block then leaves no key material on
      // the core bus, and forces a fresh key load.
      state      <= ST_FILL;
      key_w      <= '0;
      pt_w       <= '0;
      kcnt       <= 2'd0;
      pcnt       <= 2'd0;
      key_loaded <= 1'b0;
      pt_full    <= 1'b0;
      lat_cnt    <= 8'd0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_FILL: begin
          if (bus.s_valid) begin
            if (bus.s_sel) begin
              // Key words are always accepted; a wrap completes a (re)load.
              key_w[~kcnt] <= bus.s_data;
              kcnt         <= kcnt + 2'd1;
              if (kcnt == 2'd3) begin
                key_loaded <= 1'b1;
              end
            end else if (!pt_full) begin
              pt_w[~pcnt] <= bus.s_data;
              pcnt        <= pcnt + 2'd1;
              if (pcnt == 2'd3) begin
                pt_full <= 1'b1;
              end
            end else begin
              // Plaintext buffer already holds a block: drop and flag.
              err <= 1'b1;
            end
          end
          if (dispatch) begin
            state   <= ST_RUN;
            pt_full <= 1'b0;
            lat_cnt <= 8'd0;
          end
        end

        ST_RUN: begin
          lat_cnt <= lat_cnt + 8'd1;
          if (lat_cnt == LAST_CNT) begin
            m_data_q  <= cypher_text;
            m_valid_q <= 1'b1;
            state     <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (m_valid_q && bus.m_ready) begin
            m_valid_q <= 1'b0;
            state     <= ST_FILL;
          end
        end

        default: begin
          state <= ST_FILL;
        end
      endcase
    end
  end

  // Ready and busy are decoded from the state. Ready is also gated by reset,
  // so no word is taken while the block is held in reset.
  assign bus.s_ready = (state == ST_FILL) && !rst;
  assign busy        = (state != ST_FILL);

  assign key         = key_w;
  assign plain_text  = pt_w;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;

endmodule
